gsu_icache_fetch: RTL
=====================

Name: gsu_icache_fetch

Overview:
- GSU-side instruction fetch unit. It serves opcode bytes to the GSU core from the 512-byte instruction cache, which it owns.
- The SNES CPU side writes the same cache through the host port.
- On a miss inside the cache window it fills a whole 16-byte line from Game Pak ROM. Fetches outside the window go straight to ROM.

Parameters:
- LINE_BYTES, 16, bytes per cache line (fixed; sets 4-bit offset).
- NUM_LINES, 32, number of lines (512-byte cache, 32 valid flags).

Ports:
- clkin  in  1  GSU clock, all logic posedge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  core requests byte at fetch_pc; held high until fetch_ack.
- fetch_pc  in  16  R15 value; stable while fetch_req is high.
- pbr  in  8  program bank; stable during a request.
- cbr  in  16  cache base; bits [3:0] treated as 0.
- cache_flush  in  1  clears all 32 line flags.
- fetch_ack  out  1  one-cycle pulse; fetch_data valid.
- fetch_data  out  8  opcode byte.
- ROM_RD_REQ  out  1  ROM read request.
- ROM_ADDR  out  24  ROM byte address.
- ROM_RD_ACK  in  1  one-cycle pulse; ROM_DI valid that cycle.
- ROM_DI  in  8  ROM read data.
- host_we  in  1  host cache write strobe (single cycle).
- host_addr  in  9  cache byte index, already CBR-resolved.
- host_di  in  8  host write data.
- line_valid  out  32  current flag vector (for MMIO/debug).

Behaviour:
- Reset values: fetch_ack=0, fetch_data=0, ROM_RD_REQ=0, ROM_ADDR=0, line_valid=0, state IDLE.
  - Reset is asynchronous; ROM_RD_REQ drops immediately, even mid-fill.
  - Cache RAM contents are not reset.
- Window arithmetic:
  - off = fetch_pc - cbr, mod 2^16.
  - In-window iff off < 0x200; line = off[8:4], byte = off[3:0].
  - Line ROM base = {pbr, (cbr + {line,4'h0}) mod 2^16}. The bank never carries.
- States: IDLE, HIT, FILL, DIRECT, RESP.
- IDLE, on fetch_req:
  - In-window and flag[line]=1: register RAM read address off[8:0], go to HIT.
  - In-window and flag[line]=0: fill_idx=0, go to FILL.
  - Otherwise: go to DIRECT.
- HIT: fetch_ack=1, fetch_data=RAM q, go to IDLE. Hit latency is 1 cycle (req sampled at edge N, ack at edge N+1).
- FILL:
  - ROM_RD_REQ=1, ROM_ADDR=line base + fill_idx (16-bit wrap).
  - On ROM_RD_ACK: write RAM[{line,fill_idx}]=ROM_DI; if fill_idx==byte, capture ROM_DI.
  - fill_idx==15: set flag[line] (unless flushed during this fill), go to RESP. Otherwise fill_idx++.
  - ROM_RD_REQ stays high continuously across bytes; ROM_ADDR updates the cycle after each ack.
- DIRECT: ROM_RD_REQ=1, ROM_ADDR={pbr,fetch_pc}. On ack, capture ROM_DI and go to RESP. No flag or RAM change.
- RESP: fetch_ack=1 with captured byte, go to IDLE.
- ROM handshake: one outstanding read. ROM_ADDR is stable while ROM_RD_REQ is high and ack has not yet been seen.
- Host port:
  - host_we writes RAM[host_addr] in any state.
  - Writing offset 0xF of a line sets that line's flag.
  - Same-cycle collision with a fill write to the same address: host data wins.
- cache_flush:
  - Clears all flags that cycle; it has priority over any flag set in the same cycle.
  - During FILL: the fill completes and the byte is returned, but that line's flag stays 0.
- Dropping fetch_req before ack is a protocol violation. The FSM completes the transaction regardless and pulses ack once.
- A ROM_RD_ACK arriving while not in FILL or DIRECT is ignored.

Decomposition:
- Shared package gsu_pkg:
  - State enum.
  - Constants CACHE_BYTES=512, LINE_BYTES=16, CACHE_WINDOW=16'h0200.
  - Opcode constants already used by the core.
- One sub-module, gsu_cache_ram: 512x8 memory with GSU read/write port and host write port, 1-cycle registered read. The flags stay in gsu_icache_fetch.

Test Plan:
- Cold miss: reset, cbr=8000, pbr=01, fetch_pc=8012 -> ROM reads 01:8010..01:801F in order. After the 16th ack the next cycle gives fetch_ack with the 801F-ack's sibling byte (ROM[01:8012]); line_valid=0x00000002.
- Hit: after the cold miss, fetch_pc=8013 -> fetch_ack one cycle after req, data=ROM[01:8013], ROM_RD_REQ never asserted.
- Out of window: fetch_pc=7FFF -> single ROM read 01:7FFF. Then fetch_pc=8200 -> single ROM read 01:8200. line_valid unchanged.
- Host preload: host writes 0x020..0x02F with 0xA0..0xAF -> line_valid bit 2 set. Fetch 8025 -> hit returns 0xA5 with no ROM traffic.
- Wrap: cbr=FFF0, pbr=02, fetch_pc=0005 (off=0x015, line 1) -> fill reads 02:0000..02:000F, returns ROM[02:0005], bank stays 02.
- Flush/reset mid-fill:
  - cache_flush at 8th ack -> byte still returned, line_valid=0; refetching the same pc refills.
  - rst_n low mid-fill -> ROM_RD_REQ=0 immediately, line_valid=0, next request restarts at fill_idx 0.

Source files
------------

// File: rtl/gsu_pkg.sv
// Shared types and constants for the GSU instruction fetch path.
package gsu_pkg;

  localparam int          CACHE_BYTES  = 512;
  localparam int          LINE_BYTES   = 16;
  localparam logic [15:0] CACHE_WINDOW = 16'h0200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIT,
    ST_FILL,
    ST_DIRECT,
    ST_RESP
  } fetch_state_e;

  localparam logic [7:0] OP_STOP  = 8'h00;
  localparam logic [7:0] OP_NOP   = 8'h01;
  localparam logic [7:0] OP_CACHE = 8'h02;

endpackage

// File: rtl/gsu_cache_ram.sv
// 512x8 instruction cache storage: GSU fill port, host write port, registered read.
module gsu_cache_ram
  import gsu_pkg::*;
#(
  parameter int DEPTH = CACHE_BYTES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  input  logic          gsu_we_i,
  input  logic [AW-1:0] gsu_addr_i,
  input  logic [7:0]    gsu_di_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [7:0]    host_di_i
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Host write is issued last so it wins a same-address collision with a fill.
  always_ff @(posedge clk) begin
    if (gsu_we_i) begin
      mem_q[gsu_addr_i] <= gsu_di_i;
    end
    if (host_we_i) begin
      mem_q[host_addr_i] <= host_di_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gsu_icache_fetch.sv
// GSU opcode fetch: serves bytes from the 512-byte cache, line-fills on a miss
// inside the CBR window and reads ROM directly for fetches outside it.
module gsu_icache_fetch
  import gsu_pkg::fetch_state_e;
  import gsu_pkg::CACHE_WINDOW;
  import gsu_pkg::ST_IDLE;
  import gsu_pkg::ST_HIT;
  import gsu_pkg::ST_FILL;
  import gsu_pkg::ST_DIRECT;
  import gsu_pkg::ST_RESP;
#(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 32
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 fetch_req,
  input  logic [15:0]          fetch_pc,
  input  logic [7:0]           pbr,
  input  logic [15:0]          cbr,
  input  logic                 cache_flush,
  output logic                 fetch_ack,
  output logic [7:0]           fetch_data,
  output logic                 ROM_RD_REQ,
  output logic [23:0]          ROM_ADDR,
  input  logic                 ROM_RD_ACK,
  input  logic [7:0]           ROM_DI,
  input  logic                 host_we,
  input  logic [8:0]           host_addr,
  input  logic [7:0]           host_di,
  output logic [NUM_LINES-1:0] line_valid
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = $clog2(NUM_LINES);
  localparam int IDX_W  = OFF_W + LINE_W;

  fetch_state_e         state_q;
  logic [OFF_W-1:0]     fill_idx_q;
  logic                 rom_req_q;
  logic [23:0]          rom_addr_q;
  logic                 ack_q;
  logic [7:0]           fetch_data_q;
  logic                 flushed_q;
  logic [NUM_LINES-1:0] flags_q, flags_d;

  logic [LINE_W-1:0]    line_q;
  logic [OFF_W-1:0]     byte_q;
  logic [7:0]           bank_q;
  logic [15:0]          base_q;
  logic [7:0]           byte_hold_q;

  logic [15:0]          cbr_al;
  logic [15:0]          off;
  logic                 in_win;
  logic [LINE_W-1:0]    line_w;
  logic [OFF_W-1:0]     byte_w;
  logic [15:0]          base_w;
  logic                 accept;
  logic                 fill_wr;
  logic                 fill_last;
  logic [7:0]           ram_q;

  assign cbr_al = {cbr[15:OFF_W], {OFF_W{1'b0}}};
  assign off    = fetch_pc - cbr_al;
  assign in_win = off < CACHE_WINDOW;
  assign line_w = off[IDX_W-1:OFF_W];
  assign byte_w = off[OFF_W-1:0];
  assign base_w = cbr_al + 16'({line_w, {OFF_W{1'b0}}});

  // The request is held until the core has seen ack, so a request still high
  // during the ack cycle belongs to the transaction just finished.
  assign accept    = (state_q == ST_IDLE) && fetch_req && !ack_q;
  assign fill_wr   = (state_q == ST_FILL) && ROM_RD_ACK;
  assign fill_last = fill_wr && (fill_idx_q == {OFF_W{1'b1}});

  gsu_cache_ram #(
    .DEPTH (LINE_BYTES * NUM_LINES),
    .AW    (IDX_W)
  ) u_ram (
    .clk         (clkin),
    .rd_addr_i   (off[IDX_W-1:0]),
    .rd_data_o   (ram_q),
    .gsu_we_i    (fill_wr),
    .gsu_addr_i  ({line_q, fill_idx_q}),
    .gsu_di_i    (ROM_DI),
    .host_we_i   (host_we),
    .host_addr_i (host_addr),
    .host_di_i   (host_di)
  );

  always_comb begin
    flags_d = flags_q;
    if (host_we && (host_addr[OFF_W-1:0] == {OFF_W{1'b1}})) begin
      flags_d[host_addr[IDX_W-1:OFF_W]] = 1'b1;
    end
    if (fill_last && !flushed_q) begin
      flags_d[line_q] = 1'b1;
    end
    if (cache_flush) begin
      flags_d = '0;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fill_idx_q   <= '0;
      rom_req_q    <= 1'b0;
      rom_addr_q   <= '0;
      ack_q        <= 1'b0;
      fetch_data_q <= '0;
      flushed_q    <= 1'b0;
      flags_q      <= '0;
    end else begin
      ack_q   <= 1'b0;
      flags_q <= flags_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (in_win && flags_q[line_w]) begin
              state_q <= ST_HIT;
            end else if (in_win) begin
              state_q    <= ST_FILL;
              fill_idx_q <= '0;
              flushed_q  <= 1'b0;
              rom_req_q  <= 1'b1;
              rom_addr_q <= {pbr, base_w};
            end else begin
              state_q    <= ST_DIRECT;
              rom_req_q  <= 1'b1;
              rom_addr_q <= {pbr, fetch_pc};
            end
          end
        end
        ST_HIT: begin
          ack_q        <= 1'b1;
          fetch_data_q <= ram_q;
          state_q      <= ST_IDLE;
        end
        ST_FILL: begin
          // A flush seen at any point of the fill keeps this line invalid.
          if (cache_flush) begin
            flushed_q <= 1'b1;
          end
          if (ROM_RD_ACK) begin
            if (fill_idx_q == {OFF_W{1'b1}}) begin
              rom_req_q <= 1'b0;
              state_q   <= ST_RESP;
            end else begin
              fill_idx_q <= fill_idx_q + 1'b1;
              rom_addr_q <= {bank_q, base_q + 16'(fill_idx_q) + 16'd1};
            end
          end
        end
        ST_DIRECT: begin
          if (ROM_RD_ACK) begin
            rom_req_q <= 1'b0;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack_q        <= 1'b1;
          fetch_data_q <= byte_hold_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (accept) begin
      line_q <= line_w;
      byte_q <= byte_w;
      bank_q <= pbr;
      base_q <= base_w;
    end
    if (ROM_RD_ACK && (((state_q == ST_FILL) && (fill_idx_q == byte_q)) ||
                       (state_q == ST_DIRECT))) begin
      byte_hold_q <= ROM_DI;
    end
  end

  assign fetch_ack  = ack_q;
  assign fetch_data = fetch_data_q;
  assign ROM_RD_REQ = rom_req_q;
  assign ROM_ADDR   = rom_addr_q;
  assign line_valid = flags_q;

endmodule
